// File: rtl/ponto_fixo_acc_8.sv
// Streaming Q4.4 accumulator: sums N_SAMPLES upstream add/sub results, counts their
// overflow flags and hands the total downstream through a valid/ready pair.
module ponto_fixo_acc_8 #(
    parameter int N_SAMPLES = 8,
    parameter bit SAT       = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_ovf,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] acc_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       sat_flag,
    output logic [7:0] ovf_count,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [7:0] LAST = 8'(N_SAMPLES - 1);

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] ovf_q, ovf_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sat_q, sat_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic [8:0] sum;
    logic       xfer;

    assign sum  = {1'b0, acc_q} + {1'b0, in_data};
    assign xfer = in_valid & in_ready_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = 8'h00;
                    ovf_d   = 8'h00;
                    cnt_d   = 8'h00;
                    sat_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (xfer) begin
                    // Carry out of bit 7 marks the block; SAT pins the total at full scale.
                    if (sum[8]) begin
                        sat_d = 1'b1;
                        acc_d = SAT ? 8'hFF : sum[7:0];
                    end else begin
                        acc_d = sum[7:0];
                    end
                    if (in_ovf && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == LAST) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs are registered from the next state so they track it exactly.
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= 8'h00;
            ovf_q       <= 8'h00;
            cnt_q       <= 8'h00;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;
    assign sat_flag  = sat_q;
    assign ovf_count = ovf_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_ponto_fixo_acc_8.sv
// Bench for ponto_fixo_acc_8: four configurations (N=4/SAT, N=3/SAT, N=3/wrap, N=1/SAT)
// checked each cycle against an unbounded-sum model plus hand-computed pinned values.
module tb_ponto_fixo_acc_8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_ovf = 1'b0;
    logic [3:0] start_v = '0, in_valid_v = '0, out_ready_v = '0;
    logic [3:0] in_ready_v, out_valid_v, sat_v, busy_v;
    logic [7:0] acc_v [4];
    logic [7:0] ovf_v [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ponto_fixo_acc_8 #(
            .N_SAMPLES(g == 0 ? 4 : (g == 3 ? 1 : 3)),
            .SAT      (g == 2 ? 1'b0 : 1'b1)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start_v[g]),
            .in_data  (in_data),
            .in_ovf   (in_ovf),
            .in_valid (in_valid_v[g]),
            .in_ready (in_ready_v[g]),
            .acc_out  (acc_v[g]),
            .out_valid(out_valid_v[g]),
            .out_ready(out_ready_v[g]),
            .sat_flag (sat_v[g]),
            .ovf_count(ovf_v[g]),
            .busy     (busy_v[g])
        );
    end

    function automatic int nsmp(input int i);
        return (i == 0) ? 4 : ((i == 3) ? 1 : 3);
    endfunction
    function automatic bit satp(input int i);
        return i != 2;
    endfunction

    // Model: 0 idle, 1 collecting, 2 holding a result; tot is the exact sum, never truncated.
    int ph [4] = '{0, 0, 0, 0};
    int cnt[4] = '{0, 0, 0, 0};
    int tot[4] = '{0, 0, 0, 0};
    int oc [4] = '{0, 0, 0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                ph[i] = 0; cnt[i] = 0; tot[i] = 0; oc[i] = 0;
            end else begin
                case (ph[i])
                    0: if (start_v[i]) begin
                        ph[i] = 1; cnt[i] = 0; tot[i] = 0; oc[i] = 0;
                    end
                    1: if (in_valid_v[i]) begin
                        tot[i] = tot[i] + int'(in_data);
                        oc[i]  = oc[i] + int'(in_ovf);
                        cnt[i] = cnt[i] + 1;
                        if (cnt[i] == nsmp(i)) ph[i] = 2;
                    end
                    default: if (out_ready_v[i]) ph[i] = 0;
                endcase
            end
        end
    end

    function automatic int e_acc(input int i);
        if (satp(i)) return (tot[i] > 255) ? 255 : tot[i];
        return tot[i] % 256;
    endfunction

    int n_cmp = 0, n_bad = 0;
    int lit_req = 0, lit_ack = 0;
    int lit_k, lit_acc, lit_sat, lit_ovf, lit_ov, lit_ir;

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[%0d] @%0t: got %0d, expected %0d", nm, i, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("acc_out",   i, int'(acc_v[i]),       e_acc(i));
            chk("sat_flag",  i, int'(sat_v[i]),       (tot[i] > 255) ? 1 : 0);
            chk("ovf_count", i, int'(ovf_v[i]),       (oc[i] > 255) ? 255 : oc[i]);
            chk("in_ready",  i, int'(in_ready_v[i]),  (ph[i] == 1) ? 1 : 0);
            chk("out_valid", i, int'(out_valid_v[i]), (ph[i] == 2) ? 1 : 0);
            chk("busy",      i, int'(busy_v[i]),      (ph[i] != 0) ? 1 : 0);
        end
        if (lit_req != lit_ack) begin
            chk("pin_acc",  lit_k, int'(acc_v[lit_k]),       lit_acc);
            chk("pin_sat",  lit_k, int'(sat_v[lit_k]),       lit_sat);
            chk("pin_ovf",  lit_k, int'(ovf_v[lit_k]),       lit_ovf);
            chk("pin_oval", lit_k, int'(out_valid_v[lit_k]), lit_ov);
            chk("pin_irdy", lit_k, int'(in_ready_v[lit_k]),  lit_ir);
            lit_ack = lit_req;
        end
    end

    // One stimulus cycle for instance k; all other instances see idle inputs.
    task automatic cyc(input int k, input logic st, input logic v, input logic [7:0] d,
                       input logic o, input logic ordy);
        @(negedge clk);
        rst = 1'b0;
        start_v = '0; in_valid_v = '0; out_ready_v = '0;
        start_v[k] = st; in_valid_v[k] = v; out_ready_v[k] = ordy;
        in_data = d; in_ovf = o;
    endtask

    // Expected values for instance k just after the coming rising edge.
    task automatic pin(input int k, input int a, input int s, input int o, input int ov,
                       input int ir);
        lit_k = k; lit_acc = a; lit_sat = s; lit_ovf = o; lit_ov = ov; lit_ir = ir;
        lit_req++;
    endtask

    initial begin
        @(negedge clk);
        pin(0, 0, 0, 0, 0, 0);

        // 1: 4 x 1.5 = 6.0
        cyc(0, 1, 0, 8'h00, 0, 0); pin(0, 0, 0, 0, 0, 1);
        for (int j = 0; j < 3; j++) cyc(0, 0, 1, 8'h18, 0, 0);
        pin(0, 8'h48, 0, 0, 0, 1);
        cyc(0, 0, 1, 8'h18, 0, 0); pin(0, 8'h60, 0, 0, 1, 0);
        cyc(0, 0, 0, 8'h00, 0, 0); pin(0, 8'h60, 0, 0, 1, 0);
        cyc(0, 0, 0, 8'h00, 0, 1); pin(0, 8'h60, 0, 0, 0, 0);

        // 2: saturation holds at full scale
        cyc(1, 1, 0, 8'h00, 0, 0);
        cyc(1, 0, 1, 8'h80, 0, 0); pin(1, 8'h80, 0, 0, 0, 1);
        cyc(1, 0, 1, 8'h80, 0, 0); pin(1, 8'hFF, 1, 0, 0, 1);
        cyc(1, 0, 1, 8'h10, 0, 0); pin(1, 8'hFF, 1, 0, 1, 0);
        cyc(1, 0, 0, 8'h00, 0, 1); pin(1, 8'hFF, 1, 0, 0, 0);

        // 3: wrap mode
        cyc(2, 1, 0, 8'h00, 0, 0);
        cyc(2, 0, 1, 8'h80, 0, 0); pin(2, 8'h80, 0, 0, 0, 1);
        cyc(2, 0, 1, 8'h80, 0, 0); pin(2, 8'h00, 1, 0, 0, 1);
        cyc(2, 0, 1, 8'h80, 0, 0); pin(2, 8'h80, 1, 0, 1, 0);
        cyc(2, 0, 0, 8'h00, 0, 1); pin(2, 8'h80, 1, 0, 0, 0);

        // N_SAMPLES=1: first transfer completes the block
        cyc(3, 1, 0, 8'h00, 0, 0); pin(3, 0, 0, 0, 0, 1);
        cyc(3, 0, 1, 8'h25, 1, 0); pin(3, 8'h25, 0, 1, 1, 0);
        cyc(3, 0, 0, 8'h00, 0, 1); pin(3, 8'h25, 0, 1, 0, 0);

        // 4: overflow counting with gaps of 0..3 idle cycles
        cyc(0, 1, 0, 8'h00, 0, 0); pin(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 8'h01, 1, 0); pin(0, 1, 0, 1, 0, 1);
        cyc(0, 0, 0, 8'h01, 1, 0);
        cyc(0, 0, 1, 8'h01, 0, 0); pin(0, 2, 0, 1, 0, 1);
        cyc(0, 0, 0, 8'h01, 1, 0);
        cyc(0, 0, 0, 8'h01, 1, 0); pin(0, 2, 0, 1, 0, 1);
        cyc(0, 0, 1, 8'h01, 1, 0); pin(0, 3, 0, 2, 0, 1);
        for (int j = 0; j < 3; j++) cyc(0, 0, 0, 8'h01, 1, 0);
        cyc(0, 0, 1, 8'h01, 1, 0); pin(0, 4, 0, 3, 1, 0);

        // 5: backpressure; start and stray samples ignored in DONE and on release
        for (int j = 0; j < 5; j++) cyc(0, logic'(j % 2), 1, 8'h77, 1, 0);
        pin(0, 4, 0, 3, 1, 0);
        cyc(0, 1, 0, 8'h00, 0, 1); pin(0, 4, 0, 3, 0, 0);
        cyc(0, 0, 1, 8'h77, 1, 0); pin(0, 4, 0, 3, 0, 0);

        // 6: reset mid-block discards the partial sum, rst beats start/valid
        cyc(0, 1, 0, 8'h00, 0, 0);
        cyc(0, 0, 1, 8'h18, 0, 0);
        cyc(0, 0, 1, 8'h18, 0, 0); pin(0, 8'h30, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b1; start_v[0] = 1'b1; in_valid_v[0] = 1'b1; in_data = 8'h18;
        pin(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 8'h00, 0, 0); pin(0, 0, 0, 0, 0, 1);
        for (int j = 0; j < 4; j++) cyc(0, 0, 1, 8'h18, 0, 0);
        pin(0, 8'h60, 0, 0, 1, 0);
        cyc(0, 0, 0, 8'h00, 0, 1); pin(0, 8'h60, 0, 0, 0, 0);

        cyc(0, 0, 0, 8'h00, 0, 0);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
